// File: rtl/seq_detector_param.sv
// seq_detector_param
//   Serial pattern detector for an N-bit PATTERN. PATTERN[N-1] is the first
//   bit on the wire. Progress through the pattern is tracked as the length P
//   of the longest pattern prefix that is also a suffix of the consumed stream.
//   Mismatch fallback lengths come from a failure table built at elaboration.
//
// Ports
//   clk       : sole clock, rising edge
//   reset     : synchronous, active-high; clears P, z and match_cnt
//   en        : sample strobe; w is consumed only when en=1
//   w         : serial data bit
//   clr_cnt   : synchronous clear of match_cnt (wins over a same-cycle match)
//   z         : registered one-cycle match pulse
//   match_cnt : saturating count of reported matches
//   progress  : current P (0..N-1), straight from the state register
module seq_detector_param #(
    parameter int             N       = 4,
    parameter logic [N-1:0]   PATTERN = 4'b1011,
    parameter bit             OVERLAP = 1'b1,
    parameter int             CNT_W   = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 en,
    input  logic                 w,
    input  logic                 clr_cnt,
    output logic                 z,
    output logic [CNT_W-1:0]     match_cnt,
    output logic [$clog2(N)-1:0] progress
);

    localparam int PW = $clog2(N);

    // Next progress after consuming bit b in state p: the longest k < N such
    // that the last k bits of (prefix_p, b) equal the first k pattern bits.
    // For the full-match case (p = N-1, b matching) this yields the longest
    // proper border of PATTERN, i.e. the overlap restart point.
    function automatic int calc_next(int p, int b);
        int  best;
        int  si;
        bit  ok;
        bit  sb;
        best = 0;
        for (int k = 1; k < N; k++) begin
            if (k <= p + 1) begin
                ok = 1'b1;
                for (int j = 0; j < k; j++) begin
                    si = p + 1 - k + j;
                    sb = (si == p) ? (b != 0) : PATTERN[N-1-si];
                    if (sb != PATTERN[N-1-j]) ok = 1'b0;
                end
                if (ok) best = k;
            end
        end
        return best;
    endfunction

    logic [N-1:0][1:0][PW-1:0] nxt_tab;
    logic [N-1:0]              exp_bit;   // exp_bit[i] = i-th bit on the wire

    for (genvar gp = 0; gp < N; gp++) begin : g_tab
        assign exp_bit[gp] = PATTERN[N-1-gp];
        for (genvar gb = 0; gb < 2; gb++) begin : g_bit
            assign nxt_tab[gp][gb] = PW'(calc_next(gp, gb));
        end
    end

    logic [PW-1:0]    p_q, p_d;
    logic             z_q, z_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             full;

    always_comb begin
        full  = en && (p_q == PW'(N - 1)) && (w == exp_bit[p_q]);
        p_d   = p_q;
        z_d   = full;
        cnt_d = cnt_q;
        if (en) begin
            p_d = nxt_tab[p_q][w];
            if (full && !OVERLAP) p_d = '0;
        end
        if (clr_cnt)
            cnt_d = '0;
        else if (full && (cnt_q != {CNT_W{1'b1}}))
            cnt_d = cnt_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            p_q   <= '0;
            z_q   <= 1'b0;
            cnt_q <= '0;
        end else begin
            p_q   <= p_d;
            z_q   <= z_d;
            cnt_q <= cnt_d;
        end
    end

    assign z         = z_q;
    assign match_cnt = cnt_q;
    assign progress  = p_q;

endmodule

// File: tb/tb_seq_detector_param.sv
// Bench for seq_detector_param. Four instances share one stimulus stream:
//   0: N=4 1011 overlap   1: N=4 1011 non-overlap
//   2: N=2 11   overlap   3: N=4 1011 overlap, CNT_W=2
// A history-based model (last bits of the stream, compared against the
// pattern with plain arithmetic) is checked every cycle after reset, and
// directed literal checks pin the model on the documented scenarios.
module tb_seq_detector_param;

    logic clk = 1'b0;
    logic reset = 1'b0, en = 1'b0, w = 1'b0, clr_cnt = 1'b0;
    always #5 clk = ~clk;

    logic       z_a, z_b, z_c, z_d;
    logic [7:0] cnt_a, cnt_b, cnt_c;
    logic [1:0] cnt_d;
    logic [1:0] pr_a, pr_b, pr_d;
    logic [0:0] pr_c;

    seq_detector_param #(.N(4), .PATTERN(4'b1011), .OVERLAP(1'b1), .CNT_W(8)) u_a (
        .clk(clk), .reset(reset), .en(en), .w(w), .clr_cnt(clr_cnt),
        .z(z_a), .match_cnt(cnt_a), .progress(pr_a));
    seq_detector_param #(.N(4), .PATTERN(4'b1011), .OVERLAP(1'b0), .CNT_W(8)) u_b (
        .clk(clk), .reset(reset), .en(en), .w(w), .clr_cnt(clr_cnt),
        .z(z_b), .match_cnt(cnt_b), .progress(pr_b));
    seq_detector_param #(.N(2), .PATTERN(2'b11), .OVERLAP(1'b1), .CNT_W(8)) u_c (
        .clk(clk), .reset(reset), .en(en), .w(w), .clr_cnt(clr_cnt),
        .z(z_c), .match_cnt(cnt_c), .progress(pr_c));
    seq_detector_param #(.N(4), .PATTERN(4'b1011), .OVERLAP(1'b1), .CNT_W(2)) u_d (
        .clk(clk), .reset(reset), .en(en), .w(w), .clr_cnt(clr_cnt),
        .z(z_d), .match_cnt(cnt_d), .progress(pr_d));

    localparam int CN[4]  = '{4, 4, 2, 4};
    localparam int CP[4]  = '{11, 11, 3, 11};
    localparam int COV[4] = '{1, 0, 1, 1};
    localparam int CMX[4] = '{255, 255, 255, 3};

    logic [31:0] dz[4], dcnt[4], dpr[4];
    assign dz[0] = 32'(z_a);  assign dcnt[0] = 32'(cnt_a); assign dpr[0] = 32'(pr_a);
    assign dz[1] = 32'(z_b);  assign dcnt[1] = 32'(cnt_b); assign dpr[1] = 32'(pr_b);
    assign dz[2] = 32'(z_c);  assign dcnt[2] = 32'(cnt_c); assign dpr[2] = 32'(pr_c);
    assign dz[3] = 32'(z_d);  assign dcnt[3] = 32'(cnt_d); assign dpr[3] = 32'(pr_d);

    int checks = 0, errors = 0;
    bit seen_rst = 1'b0;

    // model state: bit history since last reset/restart (newest at LSB)
    logic [31:0] mh[4];
    int          mhl[4], mcnt[4], mz[4], mp[4];

    function automatic logic [31:0] msk(int k);
        return (k >= 32) ? 32'hFFFF_FFFF : ((32'd1 << k) - 32'd1);
    endfunction

    function automatic int prog_of(logic [31:0] h, int hl, int n, int p);
        int best = 0;
        for (int k = 1; k < n; k++)
            if (k <= hl && ((h & msk(k)) == (32'(p) >> (n - k)))) best = k;
        return best;
    endfunction

    task automatic chk(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
        end
    endtask

    // model update + per-cycle compare, 1 time unit after each rising edge
    initial begin
        for (int i = 0; i < 4; i++) begin
            mh[i] = '0; mhl[i] = 0; mcnt[i] = 0; mz[i] = 0; mp[i] = 0;
        end
        forever begin
            @(posedge clk);
            #1;
            for (int i = 0; i < 4; i++) begin
                if (reset) begin
                    mh[i] = '0; mhl[i] = 0; mcnt[i] = 0; mz[i] = 0;
                end else begin
                    mz[i] = 0;
                    if (en) begin
                        mh[i] = {mh[i][30:0], w};
                        if (mhl[i] < 32) mhl[i]++;
                        if (mhl[i] >= CN[i] && (mh[i] & msk(CN[i])) == 32'(CP[i])) begin
                            mz[i] = 1;
                            if (mcnt[i] < CMX[i]) mcnt[i]++;
                            if (COV[i] == 0) mhl[i] = 0;
                        end
                    end
                    if (clr_cnt) mcnt[i] = 0;
                end
                mp[i] = prog_of(mh[i], mhl[i], CN[i], CP[i]);
            end
            if (reset) seen_rst = 1'b1;
            if (seen_rst) begin
                for (int i = 0; i < 4; i++) begin
                    chk($sformatf("model_z[%0d]", i), int'(dz[i]), mz[i]);
                    chk($sformatf("model_cnt[%0d]", i), int'(dcnt[i]), mcnt[i]);
                    chk($sformatf("model_prog[%0d]", i), int'(dpr[i]), mp[i]);
                end
            end
        end
    end

    // drive on falling edge, return 2 units after the sampling rising edge
    task automatic step(input logic e, input logic b, input logic r = 1'b0, input logic c = 1'b0);
        @(negedge clk);
        en = e; w = b; reset = r; clr_cnt = c;
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        step(1'b1, 1'b1, 1'b1, 1'b1);
        en = 1'b0; reset = 1'b0; clr_cnt = 1'b0;
    endtask

    logic [6:0] s29 = 7'b1011011;
    logic [5:0] s31 = 6'b011110;
    int zcount;

    initial begin
        // reset state
        do_reset();
        chk("rst_z", int'(z_a), 0);
        chk("rst_cnt", int'(cnt_a), 0);
        chk("rst_prog", int'(pr_a), 0);

        // 1,0,1,1,0,1,1 overlapping vs non-overlapping
        for (int i = 6; i >= 0; i--) begin
            step(1'b1, s29[i]);
            if (i == 3) begin chk("ov_z_bit4", int'(z_a), 1); chk("nov_z_bit4", int'(z_b), 1); end
            if (i == 0) begin chk("ov_z_bit7", int'(z_a), 1); chk("nov_z_bit7", int'(z_b), 0); end
        end
        chk("ov_cnt", int'(cnt_a), 2);
        chk("nov_cnt", int'(cnt_b), 1);
        // non-overlap restarts empty after bit 4; 0,1,1 leaves prefix "1" matched
        chk("nov_prog", int'(pr_b), 1);
        chk("ov_prog", int'(pr_a), 1);

        // N=2 pattern 11: 0,1,1,1,1,0
        do_reset();
        for (int i = 5; i >= 0; i--) begin
            step(1'b1, s31[i]);
            chk($sformatf("n2_z_bit%0d", 6 - i), int'(z_c), (i >= 1 && i <= 3) ? 1 : 0);
        end
        chk("n2_cnt", int'(cnt_c), 3);
        chk("n2_prog", int'(pr_c), 0);

        // en gap holds progress
        do_reset();
        step(1'b1, 1'b1); step(1'b1, 1'b0); step(1'b1, 1'b1);
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 1'(i));
            chk("gap_prog", int'(pr_a), 3);
            chk("gap_z", int'(z_a), 0);
        end
        step(1'b1, 1'b1);
        chk("gap_z_final", int'(z_a), 1);
        chk("gap_cnt", int'(cnt_a), 1);

        // reset mid-pattern
        do_reset();
        step(1'b1, 1'b1); step(1'b1, 1'b0); step(1'b1, 1'b1);
        do_reset();
        step(1'b1, 1'b1);
        chk("midrst_z_bit1", int'(z_a), 0);
        chk("midrst_prog", int'(pr_a), 1);
        step(1'b1, 1'b0); step(1'b1, 1'b1); step(1'b1, 1'b1);
        chk("midrst_z_bit4", int'(z_a), 1);
        chk("midrst_cnt", int'(cnt_a), 1);

        // saturation on CNT_W=2, then clear coincident with a match
        do_reset();
        zcount = 0;
        for (int m = 0; m < 5; m++) begin
            step(1'b1, 1'b1); zcount += int'(z_d);
            step(1'b1, 1'b0); zcount += int'(z_d);
            step(1'b1, 1'b1); zcount += int'(z_d);
            step(1'b1, 1'b1); zcount += int'(z_d);
        end
        chk("sat_cnt", int'(cnt_d), 3);
        chk("sat_pulses", zcount, 5);
        step(1'b1, 1'b1); step(1'b1, 1'b0); step(1'b1, 1'b1);
        step(1'b1, 1'b1, 1'b0, 1'b1);
        chk("clr_z", int'(z_d), 1);
        chk("clr_cnt", int'(cnt_d), 0);

        // random tail, model-checked only
        for (int i = 0; i < 300; i++)
            step(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 60) == 0),
                 1'($urandom_range(0, 25) == 0));
        step(1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
